alu_muldiv_seq: RTL and testbench



---
 rtl/alu_muldiv_seq_pkg.sv | 9 +
 rtl/alu_muldiv_seq_if.sv | 15 +
 rtl/alu_carry_recover.sv | 12 +
 rtl/alu_muldiv_seq.sv | 93 +++++++++
 tb/tb_alu_muldiv_seq.sv | 117 +++++++++++
 5 files changed

// File: rtl/alu_muldiv_seq_pkg.sv
// alu_muldiv_seq_pkg: shared width, ALU op codes and sequencer states
package alu_muldiv_seq_pkg;
  localparam int WIDTH = 16;
  localparam int STEPS = 16;
  localparam logic [5:0] OP_ADD  = 6'b000000;
  localparam logic [5:0] OP_SUB  = 6'b000001;
  localparam logic [5:0] OP_IDLE = 6'b000010;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, FIN} state_t;
endpackage

// File: rtl/alu_muldiv_seq_if.sv
// alu_muldiv_seq_if: request/result bus plus the borrowed execute-ALU port
interface alu_muldiv_seq_if;
  import alu_muldiv_seq_pkg::*;
  logic             start, mode, busy, done, div_zero, alu_req;
  logic [WIDTH-1:0] opa, opb, res_hi, res_lo, alu_a, alu_b, alu_ans;
  logic [5:0]       alu_op;
  modport master (
    output start, mode, opa, opb, alu_ans,
    input  busy, done, res_hi, res_lo, div_zero, alu_req, alu_a, alu_b, alu_op
  );
  modport slave (
    input  start, mode, opa, opb, alu_ans,
    output busy, done, res_hi, res_lo, div_zero, alu_req, alu_a, alu_b, alu_op
  );
endinterface

// File: rtl/alu_carry_recover.sv
// alu_carry_recover: rebuilds add carry-out or subtract no-borrow from bit 15 of a, b and the ALU answer
module alu_carry_recover (
  input  logic a15,
  input  logic b15,
  input  logic ans15,
  input  logic sub,
  output logic c
);
  logic bb;
  assign bb = b15 ^ sub;
  assign c  = (a15 & bb) | ((a15 | bb) & ~ans15);
endmodule

// File: rtl/alu_muldiv_seq.sv
// alu_muldiv_seq: 16-step shift-add multiply / restoring divide on the shared execute ALU
module alu_muldiv_seq import alu_muldiv_seq_pkg::*; (
  input logic clk,
  input logic reset,
  alu_muldiv_seq_if.slave bus
);
  state_t state;
  logic [WIDTH-1:0] hi, lo, opr, hi_n, lo_n, src_hi, src_lo, src_opr, iss_a, iss_b;
  logic [3:0] cnt;
  logic div, spill, cy, q, src_div;
  alu_carry_recover u_carry (
    .a15(bus.alu_a[WIDTH-1]), .b15(bus.alu_b[WIDTH-1]),
    .ans15(bus.alu_ans[WIDTH-1]), .sub(div), .c(cy)
  );
  assign q = spill | cy;
  assign bus.alu_req = bus.busy;
  // Next-step operands come from the fresh start inputs in IDLE, else from this step's update
  always_comb begin
    hi_n    = div ? (q ? bus.alu_ans : bus.alu_a) : {cy, bus.alu_ans[WIDTH-1:1]};
    lo_n    = div ? {lo[WIDTH-2:0], q} : {bus.alu_ans[0], lo[WIDTH-1:1]};
    src_div = (state == IDLE) ? bus.mode : div;
    src_hi  = (state == IDLE) ? '0 : hi_n;
    src_lo  = (state == IDLE) ? (bus.mode ? bus.opa : bus.opb) : lo_n;
    src_opr = (state == IDLE) ? (bus.mode ? bus.opb : bus.opa) : opr;
    iss_a   = src_div ? {src_hi[WIDTH-2:0], src_lo[WIDTH-1]} : src_hi;
    iss_b   = (src_div | src_lo[0]) ? src_opr : '0;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      bus.busy     <= 1'b0;
      bus.done     <= 1'b0;
      bus.div_zero <= 1'b0;
      bus.res_hi   <= '0;
      bus.res_lo   <= '0;
      bus.alu_a    <= '0;
      bus.alu_b    <= '0;
      bus.alu_op   <= OP_IDLE;
      cnt          <= '0;
      hi           <= '0;
      lo           <= '0;
      opr          <= '0;
      div          <= 1'b0;
      spill        <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        IDLE: if (bus.start) begin
          div          <= bus.mode;
          hi           <= '0;
          lo           <= src_lo;
          opr          <= src_opr;
          cnt          <= '0;
          bus.div_zero <= 1'b0;
          if (bus.mode && bus.opb == '0) begin
            state        <= FIN;
            bus.done     <= 1'b1;
            bus.div_zero <= 1'b1;
            bus.res_hi   <= bus.opa;
            bus.res_lo   <= '1;
          end else begin
            state      <= ISSUE;
            bus.busy   <= 1'b1;
            bus.alu_a  <= iss_a;
            bus.alu_b  <= iss_b;
            bus.alu_op <= bus.mode ? OP_SUB : OP_ADD;
            spill      <= src_hi[WIDTH-1];
          end
        end
        ISSUE: state <= WAIT;
        WAIT: begin
          hi <= hi_n;
          lo <= lo_n;
          if (cnt == 4'(STEPS - 1)) begin
            state      <= FIN;
            bus.busy   <= 1'b0;
            bus.done   <= 1'b1;
            bus.res_hi <= hi_n;
            bus.res_lo <= lo_n;
            bus.alu_op <= OP_IDLE;
          end else begin
            state     <= ISSUE;
            cnt       <= cnt + 4'd1;
            bus.alu_a <= iss_a;
            bus.alu_b <= iss_b;
            spill     <= src_hi[WIDTH-1];
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_muldiv_seq.sv
// tb_alu_muldiv_seq: directed multiply/divide vectors against a 1-cycle registered ALU model
module tb_alu_muldiv_seq;
  import alu_muldiv_seq_pkg::*;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int tests = 0, fails = 0, cyc = 0, opcnt = 0;
  alu_muldiv_seq_if bus();
  alu_muldiv_seq dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk)
    bus.alu_ans <= reset ? 16'h0 :
                   (bus.alu_op == OP_ADD) ? bus.alu_a + bus.alu_b :
                   (bus.alu_op == OP_SUB) ? bus.alu_a - bus.alu_b : bus.alu_b;
  always @(negedge clk) if (bus.alu_op != OP_IDLE) opcnt++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic launch(input logic m, input logic [15:0] a, input logic [15:0] b);
    @(negedge clk);
    bus.start = 1'b1;
    bus.mode  = m;
    bus.opa   = a;
    bus.opb   = b;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    cyc   = 1;
    opcnt = 0;
  endtask

  task automatic finish_op(input string tag, input int lat, input logic [31:0] res,
                           input logic dz, input int ops);
    while (!bus.done && cyc < 50) tick();
    check({tag, "_lat"}, cyc, lat);
    check({tag, "_res"}, {bus.res_hi, bus.res_lo}, res);
    check({tag, "_dz"}, {31'd0, bus.div_zero}, {31'd0, dz});
    check({tag, "_op_fin"}, {26'd0, bus.alu_op}, {26'd0, OP_IDLE});
    tick();
    check({tag, "_pulse"}, {31'd0, bus.done}, 32'd0);
    check({tag, "_ops"}, opcnt / 2, ops);
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_ctl"}, {28'd0, bus.busy, bus.done, bus.div_zero, bus.alu_req}, 32'd0);
    check({tag, "_res"}, {bus.res_hi, bus.res_lo}, 32'd0);
    check({tag, "_ab"}, {bus.alu_a, bus.alu_b}, 32'd0);
    check({tag, "_op"}, {26'd0, bus.alu_op}, {26'd0, OP_IDLE});
  endtask

  initial begin
    int seen;
    bus.start = 1'b0;
    bus.mode  = 1'b0;
    bus.opa   = 16'h0;
    bus.opb   = 16'h0;
    repeat (3) @(posedge clk);
    #1;
    check_reset("rst");
    reset = 1'b0;
    launch(1'b0, 16'h0003, 16'h0005);
    check("mul_busy", {30'd0, bus.busy, bus.alu_req}, 32'd3);
    finish_op("mul3x5", 33, 32'h0000_000F, 1'b0, 16);
    launch(1'b0, 16'hFFFF, 16'hFFFF);
    finish_op("mulmax", 33, 32'hFFFE_0001, 1'b0, 16);
    launch(1'b1, 16'hFFFF, 16'h0010);
    finish_op("div_ffff_10", 33, 32'h000F_0FFF, 1'b0, 16);
    launch(1'b1, 16'h8000, 16'hFFFF);
    finish_op("div_8000_ffff", 33, 32'h8000_0000, 1'b0, 16);
    launch(1'b1, 16'hFFFE, 16'h8001);
    finish_op("div_fffe_8001", 33, 32'h7FFD_0001, 1'b0, 16);
    launch(1'b1, 16'h0064, 16'h0007);
    finish_op("div_100_7", 33, 32'h0002_000E, 1'b0, 16);
    launch(1'b1, 16'h1234, 16'h0000);
    check("divz_busy", {31'd0, bus.busy}, 32'd0);
    finish_op("divz", 1, 32'h1234_FFFF, 1'b1, 0);
    repeat (3) tick();
    check("dz_hold", {31'd0, bus.div_zero}, 32'd1);
    launch(1'b0, 16'h1234, 16'h0010);
    while (cyc < 10) tick();
    @(negedge clk);
    bus.start = 1'b1;
    bus.mode  = 1'b1;
    bus.opa   = 16'h0000;
    bus.opb   = 16'h0000;
    tick();
    bus.start = 1'b0;
    finish_op("mul_ignore", 33, 32'h0001_2340, 1'b0, 16);
    launch(1'b0, 16'h0003, 16'h0005);
    while (cyc < 20) tick();
    reset = 1'b1;
    tick();
    check_reset("midrst");
    reset = 1'b0;
    seen = 0;
    repeat (40) begin
      tick();
      if (bus.done) seen++;
    end
    check("midrst_nodone", seen, 0);
    launch(1'b0, 16'h0003, 16'h0005);
    finish_op("mul_after_rst", 33, 32'h0000_000F, 1'b0, 16);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
